// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the MEM-stage to 16-bit SRAM bridge.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WADDR_W     = SRAM_ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    PAD,
    DONE
  } state_t;

  function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [WADDR_W-1:0] waddr,
                                                       input logic hi);
    return {waddr, hi};
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response bundle of sram_ctrl.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;

  modport master (output wr_en, rd_en, address, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, address, wdata, output rdata, ready);

endinterface

// File: rtl/sram_read_buf.sv
// One-entry read buffer with write-through; compiled only with SRAM_CTRL_READ_BUF_EN.
`ifdef SRAM_CTRL_READ_BUF_EN
module sram_read_buf
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WADDR_W-1:0] lookup_addr,
  output logic               hit,
  output logic [WORD_W-1:0]  hit_data,
  input  logic               fill_en,
  input  logic [WADDR_W-1:0] fill_addr,
  input  logic [WORD_W-1:0]  fill_data,
  input  logic               wt_en,
  input  logic [WADDR_W-1:0] wt_addr,
  input  logic [WORD_W-1:0]  wt_data
);

  logic               valid;
  logic [WADDR_W-1:0] addr_q;
  logic [WORD_W-1:0]  data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (fill_en) begin
      valid  <= 1'b1;
      addr_q <= fill_addr;
      data_q <= fill_data;
    end else if (wt_en && valid && (wt_addr == addr_q)) begin
      data_q <= wt_data;
    end
  end

  assign hit      = valid && (lookup_addr == addr_q);
  assign hit_data = data_q;

endmodule
`endif

// File: rtl/sram_ctrl.sv
// 32-bit MEM-stage port to 16-bit SRAM: two half-word cycles padded to ACCESS_CYCLES.
// Optional one-entry read buffer under `SRAM_CTRL_READ_BUF_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR     = 32'd1024,
  parameter int unsigned       ACCESS_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_ctrl_if.slave             bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  // PAD lasts ACCESS_CYCLES-4 cycles; counter is loaded with that count minus one.
  localparam bit         PAD_EN   = (ACCESS_CYCLES > 4);
  localparam logic [15:0] PAD_LOAD = PAD_EN ? 16'(ACCESS_CYCLES - 5) : '0;

  state_t state, next;

  logic [WORD_W-1:0]      req_off;
  logic [WADDR_W-1:0]     req_waddr;
  logic [WADDR_W-1:0]     waddr_q;
  logic [WORD_W-1:0]      wdata_q;
  logic [WORD_W-1:0]      rdata_q;
  logic [15:0]            pad_cnt;
  logic                   buf_hit;
  logic [WORD_W-1:0]      buf_data;
  logic                   hit_now;
  logic                   dq_oe;
  logic [SRAM_DATA_W-1:0] dq_out;

  assign req_off   = bus.address - BASE_ADDR;
  assign req_waddr = WADDR_W'(req_off >> 2);
  assign hit_now   = (state == IDLE) && bus.rd_en && !bus.wr_en && buf_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (bus.wr_en)                 next = WR_LO;
        else if (bus.rd_en && !buf_hit) next = RD_LO;
      end
      RD_LO:        next = RD_HI;
      WR_LO:        next = WR_HI;
      RD_HI, WR_HI: next = PAD_EN ? PAD : DONE;
      PAD:          if (pad_cnt == '0) next = DONE;
      DONE:         next = IDLE;
      default:      next = IDLE;
    endcase
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    case (state)
      RD_LO: SRAM_ADDR = half_addr(waddr_q, 1'b0);
      RD_HI: SRAM_ADDR = half_addr(waddr_q, 1'b1);
      WR_LO: begin
        SRAM_ADDR = half_addr(waddr_q, 1'b0);
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = wdata_q[SRAM_DATA_W-1:0];
      end
      WR_HI: begin
        SRAM_ADDR = half_addr(waddr_q, 1'b1);
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = wdata_q[WORD_W-1:SRAM_DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      pad_cnt <= '0;
    end else begin
      if ((state == IDLE) && (next != IDLE)) begin
        waddr_q <= req_waddr;
        wdata_q <= bus.wdata;
      end
      if (state == RD_LO) rdata_q[SRAM_DATA_W-1:0]      <= SRAM_DQ;
      if (state == RD_HI) rdata_q[WORD_W-1:SRAM_DATA_W] <= SRAM_DQ;
      if ((state == RD_HI) || (state == WR_HI))   pad_cnt <= PAD_LOAD;
      else if ((state == PAD) && (pad_cnt != '0)) pad_cnt <= pad_cnt - 16'd1;
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign bus.ready = (state == DONE) || ((state == IDLE) && !bus.rd_en && !bus.wr_en) || hit_now;
  assign bus.rdata = hit_now ? buf_data : rdata_q;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

`ifdef SRAM_CTRL_READ_BUF_EN
  logic rd_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rd_op_q <= 1'b0;
    else if (state == IDLE) rd_op_q <= !bus.wr_en;
  end

  sram_read_buf u_read_buf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (req_waddr),
    .hit         (buf_hit),
    .hit_data    (buf_data),
    .fill_en     ((state == DONE) && rd_op_q),
    .fill_addr   (waddr_q),
    .fill_data   (rdata_q),
    .wt_en       ((state == IDLE) && bus.wr_en),
    .wt_addr     (req_waddr),
    .wt_data     (bus.wdata)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Simultaneous requests: the write is taken and the read silently dropped.
  conflict_drop: assert property (@(posedge clk) disable iff (rst)
                   !((state == IDLE) && bus.rd_en && bus.wr_en))
    else $warning("sram_ctrl: rd_en and wr_en both high, read dropped in favour of write");

endmodule
